// File: rtl/seq_alu_if.sv
// Bus bundle between the control unit and seq_alu: request fields driven by
// the control unit, results and handshake status driven back by the ALU.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               start;
  logic [3:0]         op;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [SHAMT_W-1:0] shiftamt;
  logic [WIDTH-1:0]   z;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               overflow;
  logic               zero;
  logic               div_by_zero;
  logic               busy;
  logic               done;

  modport master (
    output start, op, x, y, shiftamt,
    input  z, hi, lo, overflow, zero, div_by_zero, busy, done
  );

  modport slave (
    input  start, op, x, y, shiftamt,
    output z, hi, lo, overflow, zero, div_by_zero, busy, done
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith/shift ops into z, plus
// iterative shift-add multiply and restoring divide into the HI/LO pair.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_SLL   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   z_q, z_d, hi_q, hi_d, lo_q, lo_d;
  logic               zero_q, zero_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               is_mult_q, is_mult_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  logic [WIDTH-1:0]   sum, diff, alu_z;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;
  logic               op_iter, op_mul, op_div, op_signed, x_neg, y_neg;
  logic [WIDTH-1:0]   mag_x, mag_y;

  // Single-cycle result and add/sub overflow, computed from the bus inputs so they land in z at the accepting edge
  always_comb begin
    sum     = bus.x + bus.y;
    diff    = bus.x - bus.y;
    alu_z   = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_z   = sum;
        alu_ovf = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]);
      end
      OP_SUB: begin
        alu_z   = diff;
        alu_ovf = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (diff[WIDTH-1] != bus.x[WIDTH-1]);
      end
      OP_AND:  alu_z = bus.x & bus.y;
      OP_OR:   alu_z = bus.x | bus.y;
      OP_XOR:  alu_z = bus.x ^ bus.y;
      OP_NOR:  alu_z = ~(bus.x | bus.y);
      OP_SLT:  alu_z = {{(WIDTH-1){1'b0}}, $signed(bus.x) < $signed(bus.y)};
      OP_SLTU: alu_z = {{(WIDTH-1){1'b0}}, bus.x < bus.y};
      OP_SLL:  alu_z = bus.x << bus.shiftamt;
      OP_SRL:  alu_z = bus.x >> bus.shiftamt;
      OP_SRA:  alu_z = $unsigned($signed(bus.x) >>> bus.shiftamt);
      default: alu_z = '0;
    endcase
  end

  // Operand decode at acceptance: signed ops run on magnitudes, sign fix-up happens once at the end
  always_comb begin
    op_mul    = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
    op_iter   = op_mul || op_div;
    op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    x_neg     = op_signed && bus.x[WIDTH-1];
    y_neg     = op_signed && bus.y[WIDTH-1];
    mag_x     = x_neg ? -bus.x : bus.x;
    mag_y     = y_neg ? -bus.y : bus.y;
  end

  // One iteration step: multiply shifts {carry,rem,quo} right after a conditional add; divide shifts left and trial-subtracts
  always_comb begin
    mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvs_q};
    if (is_mult_q) begin
      step_rem = mul_sum[WIDTH:1];
      step_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
    end else if (div_shift[WIDTH] || !div_diff[WIDTH]) begin
      step_rem = div_diff[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = div_shift[WIDTH-1:0];
      step_quo = {quo_q[WIDTH-2:0], 1'b0};
    end
    prod_mag = {step_rem, step_quo};
    prod     = neg_res_q ? -prod_mag : prod_mag;
    fin_hi   = is_mult_q ? prod[2*WIDTH-1:WIDTH] : (neg_rem_q ? -step_rem : step_rem);
    fin_lo   = is_mult_q ? prod[WIDTH-1:0]       : (neg_res_q ? -step_quo : step_quo);
  end

  // Handshake FSM and next values of all result/datapath registers; requests are accepted in IDLE and DONE
  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    is_mult_d = is_mult_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      S_RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(WIDTH-1)) begin
          state_d = S_DONE;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          if (!is_mult_q) dbz_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (bus.start) begin
          if (op_div && (bus.y == '0)) begin
            hi_d    = bus.x;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else if (op_iter) begin
            is_mult_d = op_mul;
            neg_res_d = x_neg ^ y_neg;
            neg_rem_d = x_neg;
            rem_d     = '0;
            quo_d     = op_mul ? mag_y : mag_x;
            dvs_d     = op_mul ? mag_x : mag_y;
            cnt_d     = '0;
            state_d   = S_RUN;
          end else begin
            z_d     = alu_z;
            zero_d  = (alu_z == '0);
            ovf_d   = alu_ovf;
            state_d = S_DONE;
          end
        end
      end
    endcase
  end

  // Register update with synchronous active-low reset that also aborts any op in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      z_q       <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      is_mult_q <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_q       <= z_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      is_mult_q <= is_mult_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign bus.z           = z_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=32: a constant vector table, randomized ops against
// an arithmetic reference model, and hand sequences for reset abort and back-to-back.
module tb_seq_alu;
  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_RSVD  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULT  = 4'b1011;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_SLL   = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] exp_z;
    logic        exp_ovf;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dbz;
    int          exp_edges;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          pass_cnt = 0;
  int          check_cnt = 0;
  logic [31:0] m_z, m_hi, m_lo;
  logic        m_ovf, m_dbz;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                              input logic [4:0] sh, input logic [31:0] ez, input logic eovf,
                              input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                              input int eedges);
    vec_t v;
    v.op = op; v.x = x; v.y = y; v.sh = sh;
    v.exp_z = ez; v.exp_ovf = eovf; v.exp_hi = ehi; v.exp_lo = elo;
    v.exp_dbz = edbz; v.exp_edges = eedges;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Issues one request at the current cycle and waits (bounded) for done; optional start noise while busy
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                               input logic [4:0] sh, input bit noise,
                               output int edges, output int busy_cyc);
    bus.start = 1'b1; bus.op = op; bus.x = x; bus.y = y; bus.shiftamt = sh;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 4'($urandom); bus.x = $urandom; bus.y = $urandom; bus.shiftamt = 5'($urandom);
    edges = 1;
    busy_cyc = 0;
    while (!bus.done && edges < 100) begin
      if (bus.busy) busy_cyc++;
      bus.start = noise && bus.busy && ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      edges++;
    end
    bus.start = 1'b0;
  endtask

  // Compares every output against the expected state held in m_*
  task automatic checkState(input string tag, input int exp_edges, input int edges, input int busy_cyc);
    checkOutput({tag, ".z"},     bus.z, m_z);
    checkOutput({tag, ".zero"},  bus.zero, m_z == 32'd0);
    checkOutput({tag, ".ovf"},   bus.overflow, m_ovf);
    checkOutput({tag, ".hi"},    bus.hi, m_hi);
    checkOutput({tag, ".lo"},    bus.lo, m_lo);
    checkOutput({tag, ".dbz"},   bus.div_by_zero, m_dbz);
    checkOutput({tag, ".done"},  bus.done, 1'b1);
    checkOutput({tag, ".edges"}, edges, exp_edges);
    checkOutput({tag, ".busy"},  busy_cyc, (exp_edges > 1) ? 32 : 0);
  endtask

  // Reference model: plain 64-bit arithmetic from the op definitions
  task automatic modelOp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] sh, output int exp_edges);
    longint      sx, sy, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    exp_edges = 1;
    case (op)
      OP_ADD:   begin r = sx + sy; m_z = r[31:0]; m_ovf = (r > SMAX) || (r < SMIN); end
      OP_SUB:   begin r = sx - sy; m_z = r[31:0]; m_ovf = (r > SMAX) || (r < SMIN); end
      OP_AND:   begin m_z = x & y; m_ovf = 1'b0; end
      OP_OR:    begin m_z = x | y; m_ovf = 1'b0; end
      OP_XOR:   begin m_z = x ^ y; m_ovf = 1'b0; end
      OP_NOR:   begin m_z = ~(x | y); m_ovf = 1'b0; end
      OP_RSVD:  begin m_z = 32'd0; m_ovf = 1'b0; end
      OP_SLT:   begin m_z = (sx < sy) ? 32'd1 : 32'd0; m_ovf = 1'b0; end
      OP_SLTU:  begin m_z = (x < y) ? 32'd1 : 32'd0; m_ovf = 1'b0; end
      OP_SLL:   begin u = {32'd0, x} << sh; m_z = u[31:0]; m_ovf = 1'b0; end
      OP_SRL:   begin u = {32'd0, x} >> sh; m_z = u[31:0]; m_ovf = 1'b0; end
      OP_SRA:   begin r = sx >>> sh; m_z = r[31:0]; m_ovf = 1'b0; end
      OP_MULT:  begin r = sx * sy; {m_hi, m_lo} = r; exp_edges = 33; end
      OP_MULTU: begin u = {32'd0, x} * {32'd0, y}; {m_hi, m_lo} = u; exp_edges = 33; end
      OP_DIV: begin
        if (y == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = x; m_dbz = 1'b1; end
        else begin
          r = sx / sy; m_lo = r[31:0];
          r = sx % sy; m_hi = r[31:0];
          m_dbz = 1'b0; exp_edges = 33;
        end
      end
      default: begin
        if (y == 32'd0) begin m_lo = 32'hFFFFFFFF; m_hi = x; m_dbz = 1'b1; end
        else begin
          m_lo = x / y; m_hi = x % y;
          m_dbz = 1'b0; exp_edges = 33;
        end
      end
    endcase
  endtask

  task automatic modelReset();
    m_z = 32'd0; m_hi = 32'd0; m_lo = 32'd0; m_ovf = 1'b0; m_dbz = 1'b0;
  endtask

  initial begin
    int          edges, busy_cyc, exp_edges;
    logic [3:0]  op;
    logic [31:0] x, y;
    logic [4:0]  sh;
    bit          done_seen;

    // single-cycle vectors (hi/lo/dbz still at reset values)
    vecs.push_back(mk(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_RSVD, 32'h00000005, 32'h00000006, 5'd0,  32'h00000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB,  32'h00000000, 32'h80000000, 5'd0,  32'h80000000, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SRA,  32'h80000000, 32'h00000000, 5'd4,  32'hF8000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SRL,  32'h80000000, 32'h00000000, 5'd4,  32'h08000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SLL,  32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB,  32'h7FFFFFFF, 32'h80000000, 5'd0,  32'hFFFFFFFF, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_ADD,  32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1, 0, 0, 0, 1));
    vecs.push_back(mk(OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1, 0, 0, 0, 1));
    // iterative vectors: z/overflow must hold the last single-cycle result
    vecs.push_back(mk(OP_MULT,  32'hFFFFFFFE, 32'h00000003, 5'd0, 32'h7FFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 33));
    vecs.push_back(mk(OP_MULTU, 32'hFFFFFFFE, 32'h00000003, 5'd0, 32'h7FFFFFFF, 1, 32'h00000002, 32'hFFFFFFFA, 0, 33));
    vecs.push_back(mk(OP_DIVU,  32'h00000007, 32'h00000000, 5'd0, 32'h7FFFFFFF, 1, 32'h00000007, 32'hFFFFFFFF, 1, 1));
    vecs.push_back(mk(OP_MULT,  32'h00000005, 32'h00000007, 5'd0, 32'h7FFFFFFF, 1, 32'h00000000, 32'h00000023, 1, 33));
    vecs.push_back(mk(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 5'd0, 32'h7FFFFFFF, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33));
    vecs.push_back(mk(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h7FFFFFFF, 1, 32'h00000000, 32'h80000000, 0, 33));
    vecs.push_back(mk(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 5'd0, 32'h7FFFFFFF, 1, 32'h00000001, 32'hFFFFFFFD, 0, 33));
    vecs.push_back(mk(OP_DIV,   32'h00000000, 32'h00000000, 5'd0, 32'h7FFFFFFF, 1, 32'h00000000, 32'hFFFFFFFF, 1, 1));
    vecs.push_back(mk(OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 5'd0, 32'h7FFFFFFF, 1, 32'h0000000F, 32'h0FFFFFFF, 0, 33));
    vecs.push_back(mk(OP_ADD,   32'h00000002, 32'h00000003, 5'd0, 32'h00000005, 0, 32'h0000000F, 32'h0FFFFFFF, 0, 1));

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 4'd0; bus.x = 32'd0; bus.y = 32'd0; bus.shiftamt = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput("reset.z", bus.z, 32'd0);
    checkOutput("reset.zero", bus.zero, 1'b1);
    checkOutput("reset.hi", bus.hi, 32'd0);
    checkOutput("reset.lo", bus.lo, 32'd0);
    checkOutput("reset.ovf", bus.overflow, 1'b0);
    checkOutput("reset.dbz", bus.div_by_zero, 1'b0);
    checkOutput("reset.busy", bus.busy, 1'b0);
    checkOutput("reset.done", bus.done, 1'b0);
    rst_n = 1'b1;

    $display("[TB] vector table: %0d entries", vecs.size());
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].sh, 1'b1, edges, busy_cyc);
      m_z = vecs[i].exp_z; m_ovf = vecs[i].exp_ovf;
      m_hi = vecs[i].exp_hi; m_lo = vecs[i].exp_lo; m_dbz = vecs[i].exp_dbz;
      checkState($sformatf("vec%0d", i), vecs[i].exp_edges, edges, busy_cyc);
    end

    $display("[TB] randomized ops against reference model");
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = $urandom;
      sh = 5'($urandom);
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 9));
        3: x = x | 32'h80000000;
        4: y = x;
        default: ;
      endcase
      modelOp(op, x, y, sh, exp_edges);
      applyStimulus(op, x, y, sh, (i % 2) == 0, edges, busy_cyc);
      checkState($sformatf("rand%0d", i), exp_edges, edges, busy_cyc);
    end

    $display("[TB] reset during mult");
    bus.start = 1'b1; bus.op = OP_MULT; bus.x = 32'd1234; bus.y = 32'd5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 9; c++) begin @(posedge clk); #1; end
    checkOutput("abort.busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("abort.z", bus.z, 32'd0);
    checkOutput("abort.zero", bus.zero, 1'b1);
    checkOutput("abort.hi", bus.hi, 32'd0);
    checkOutput("abort.lo", bus.lo, 32'd0);
    checkOutput("abort.ovf", bus.overflow, 1'b0);
    checkOutput("abort.dbz", bus.div_by_zero, 1'b0);
    checkOutput("abort.busy", bus.busy, 1'b0);
    checkOutput("abort.done", bus.done, 1'b0);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_seen = 1'b1;
    end
    checkOutput("abort.quiet", done_seen, 1'b0);
    modelReset();
    modelOp(OP_ADD, 32'd2, 32'd3, 5'd0, exp_edges);
    applyStimulus(OP_ADD, 32'd2, 32'd3, 5'd0, 1'b0, edges, busy_cyc);
    checkState("abort.add", exp_edges, edges, busy_cyc);
    checkOutput("abort.add_z", bus.z, 32'd5);

    $display("[TB] back-to-back divu then add");
    applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd0, 1'b0, edges, busy_cyc);
    checkOutput("b2b.div_edges", edges, 33);
    checkOutput("b2b.div_hi", bus.hi, 32'd2);
    checkOutput("b2b.div_lo", bus.lo, 32'd14);
    bus.start = 1'b1; bus.op = OP_ADD; bus.x = 32'd10; bus.y = 32'd20;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("b2b.add_z", bus.z, 32'd30);
    checkOutput("b2b.add_done", bus.done, 1'b1);
    checkOutput("b2b.hi_held", bus.hi, 32'd2);
    checkOutput("b2b.lo_held", bus.lo, 32'd14);
    checkOutput("b2b.busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    checkOutput("b2b.done_drop", bus.done, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised multi-cycle ALU for the MIPS datapath. It supersedes the fixed 32-bit combinational ALU.
- Keeps the existing single-cycle op encodings (add, sub, and, or, sll).
- Adds xor, nor, slt/sltu, srl/sra and iterative mult/multu/div/divu writing a HI/LO pair.
- A start/busy/done handshake lets the control unit stall the pipeline during iterative ops.

Parameters:
WIDTH, 32, operand/result width; must be a power of two and at least 8.
SHAMT_W, $clog2(WIDTH), shift-amount width; a localparam derived from WIDTH, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
start  input  1  op request; accepted only when busy=0
op  input  4  operation code (see Behaviour)
x  input  WIDTH  operand 1 (rs)
y  input  WIDTH  operand 2 (rt/imm)
shiftamt  input  SHAMT_W  shift amount (instruction shamt field)
z  output  WIDTH  registered result of single-cycle ops
hi  output  WIDTH  mult: upper product half; div: remainder
lo  output  WIDTH  mult: lower product half; div: quotient
overflow  output  1  signed overflow for add/sub
zero  output  1  z==0, registered with z
div_by_zero  output  1  set when the last div/divu had y==0
busy  output  1  iterative op in progress
done  output  1  one-cycle pulse at op completion

Behaviour:
- Reset (rst_n=0 at a clk edge): z, hi, lo, overflow, div_by_zero, busy, done = 0; zero=1; FSM to IDLE. An in-flight iterative op is aborted with no done pulse.
- Operands, op and shiftamt are latched at the accepting edge. Later input changes do not affect the op in progress.
- start while busy=1 is ignored. start in the cycle done=1 is accepted, so back-to-back ops are allowed.
- Single-cycle ops complete one edge after acceptance: z, zero, overflow update and done=1 for one cycle. hi/lo are held.
  - 0010 add; 0110 sub; 0000 and; 0001 or; 0011 xor; 0100 nor.
  - 0111 slt (signed), 1000 sltu (unsigned): z = {0..,1} or 0.
  - 1110 sll, 1001 srl (logical), 1010 sra (arithmetic), each shifting x by shiftamt.
  - 0101 reserved: z=0, overflow=0, done pulses.
- overflow is set only for add/sub:
  - add: x,y same sign and result sign differs.
  - sub: x,y differ in sign and result sign differs from x. This covers y=MIN correctly, with no negate-y shortcut.
  - overflow=0 for all other single-cycle ops. It holds its value during iterative ops.
- Iterative ops: 1011 mult, 1100 multu, 1101 div, 1110-free code 1111 divu.
  - FSM: IDLE -> RUN (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
  - busy=1 in RUN. done=1 in DONE, when hi/lo are final. Total latency is WIDTH+1 edges from acceptance.
  - mult/multu: shift-add, one bit per cycle; {hi,lo} = full 2*WIDTH product. Signed mult operates on magnitudes and negates at the end.
  - div/divu: restoring division, one quotient bit per cycle.
    - Signed div truncates toward zero; the remainder takes the dividend's sign.
    - MIN / -1 gives lo=MIN, hi=0, with no trap and no overflow flag.
  - y==0 for div/divu: 1-cycle completion (DONE on the next edge, busy never asserted). Result: lo = all ones, hi = x, div_by_zero=1.
  - Any other div/divu clears div_by_zero. mult/multu leave it unchanged.
- z and zero are unchanged by iterative ops. hi/lo are unchanged by single-cycle ops and only update at DONE, never partially during RUN.

Test Plan:
1. WIDTH=32: add x=7FFFFFFF, y=1 -> z=80000000, overflow=1, zero=0, done one cycle after start. sub x=0, y=80000000 -> z=80000000, overflow=1.
2. slt x=FFFFFFFF, y=1 -> z=1; sltu on the same operands -> z=0. sra x=80000000, shiftamt=4 -> z=F8000000; srl -> z=08000000.
3. mult x=FFFFFFFE (-2), y=3 -> hi=FFFFFFFF, lo=FFFFFFFA. multu on the same operands -> hi=2, lo=FFFFFFFA. In both cases busy=1 for 32 cycles and done at edge 33; start pulses during busy are ignored.
4. div x=FFFFFFF9 (-7), y=2 -> lo=FFFFFFFD, hi=FFFFFFFF. divu x=7, y=0 -> done after 1 edge, lo=FFFFFFFF, hi=7, div_by_zero=1, busy stays 0.
5. Start mult, assert rst_n=0 at cycle 10 -> all outputs 0, zero=1, no done. Then issue add 2+3 -> z=5 after one cycle.
6. Back-to-back: start divu 100/7 and assert start+add in the done cycle -> hi=2, lo=14 held, and z from the add appears on the next edge.
